// File: rtl/boot_pkg.sv
// Shared types and constants for the boot ROM loader.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    CSUM,
    RUN,
    ERROR
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/inst_rom.sv
// Instruction memory: synchronous write from the loader, asynchronous read for the CPU.
module inst_rom #(
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/boot_rom_loader.sv
// Loads a framed program image from a byte stream into the instruction ROM and
// holds the CPU in reset until the image checksum has verified.
module boot_rom_loader
  import boot_pkg::*;
#(
  parameter int ROM_AW      = 15,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic [14:0] pc,
  output logic [15:0] inst,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  localparam int              TW        = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0]   TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [16:0]     ROM_DEPTH = 17'(1) << ROM_AW;

  state_e              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [7:0]          hi_q, hi_d;
  logic [7:0]          csum_q, csum_d;
  logic [ROM_AW-1:0]   wr_addr_q, wr_addr_d;
  logic [15:0]         wc_q, wc_d;
  logic [TW-1:0]       to_q, to_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                in_load;
  logic [15:0]         len_rx;
  logic [7:0]          csum_rx;
  logic                rom_we;

  assign in_load = state_q inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM};
  assign len_rx  = {hi_q, rx_data};
  assign csum_rx = csum_q + rx_data;
  assign rom_we  = rx_valid && (state_q == DATA_LO);

  inst_rom #(.AW(ROM_AW)) u_rom (
    .clk   (clk),
    .we    (rom_we),
    .waddr (wr_addr_q),
    .wdata ({hi_q, rx_data}),
    .raddr (pc[ROM_AW-1:0]),
    .rdata (inst)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      hi_q        <= '0;
      csum_q      <= '0;
      wr_addr_q   <= '0;
      wc_q        <= '0;
      to_q        <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      hi_q        <= hi_d;
      csum_q      <= csum_d;
      wr_addr_q   <= wr_addr_d;
      wc_q        <= wc_d;
      to_q        <= to_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    hi_d      = hi_q;
    csum_d    = csum_q;
    wr_addr_d = wr_addr_q;
    wc_d      = wc_q;
    to_d      = '0;
    if (in_load && !rx_valid) begin
      to_d = to_q + TW'(1);
    end
    if (rx_valid) begin
      unique case (state_q)
        IDLE, RUN, ERROR: begin
          if (rx_data == SYNC_BYTE) begin
            state_d   = LEN_HI;
            csum_d    = '0;
            wr_addr_d = '0;
            wc_d      = '0;
          end
        end
        LEN_HI: begin
          hi_d    = rx_data;
          csum_d  = csum_rx;
          state_d = LEN_LO;
        end
        LEN_LO: begin
          len_d   = len_rx;
          csum_d  = csum_rx;
          state_d = (len_rx == 16'd0 || {1'b0, len_rx} > ROM_DEPTH) ? ERROR : DATA_HI;
        end
        DATA_HI: begin
          hi_d    = rx_data;
          csum_d  = csum_rx;
          state_d = DATA_LO;
        end
        DATA_LO: begin
          csum_d    = csum_rx;
          wr_addr_d = wr_addr_q + ROM_AW'(1);
          wc_d      = wc_q + 16'd1;
          state_d   = (wc_q + 16'd1 == len_q) ? CSUM : DATA_HI;
        end
        CSUM: begin
          state_d = (csum_rx == 8'd0) ? RUN : ERROR;
        end
        default: state_d = IDLE;
      endcase
    end else if (in_load && to_q == TO_LAST) begin
      // a byte on the terminal-count cycle takes priority over the abort
      state_d = ERROR;
    end
  end

  always_comb begin
    cpu_reset_d = (state_d != RUN);
    busy_d      = state_d inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM};
    done_d      = (state_d == RUN);
    error_d     = (state_d == ERROR);
  end

  assign cpu_reset  = cpu_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = wc_q;

endmodule
